idu_queue: RTL and testbench
============================

Name: idu_queue

Overview:
- Parametrised successor to the single-register decode stage.
- Decodes one RV32I/RV64I(+M) instruction per cycle from IFU into a registered decode bundle, held in a DEPTH-entry decoded-instruction queue.
- Valid/ready handshakes on both sides give real backpressure toward IFU.
- Sits between IFU and EXU. Supports pipeline flush and XLEN=32/64 builds.

Parameters:
XLEN, 64, datapath/PC/immediate width; legal values 32 or 64
DEPTH, 4, queue entries; power of two, 2..16
RESET_PC, 64'h80000000, reset value of idu_pc (truncated to XLEN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
flush  in  1  discard all queued entries and any input this cycle
ifu_vld  in  1  IFU offers an instruction
ifu_rdy  out  1  queue can accept (count < DEPTH)
ifu_inst  in  32  instruction word
ifu_pc  in  XLEN  PC of ifu_inst
idu_vld  out  1  head entry valid
exu_rdy  in  1  EXU consumes head
idu_pc  out  XLEN  head PC
idu_inst  out  32  head instruction word
rd / rs1 / rs2  out  5 each  register indices (inst[11:7], [19:15], [24:20])
imm  out  XLEN  sign-extended immediate
fmt  out  6  one-hot {B,R,J,S,U,I}; 0 if illegal
ctl  out  12  {illegal,w_inst,mul,div,sys,jalr,jal,br,st,ld,wb,sign}
idu_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async assert, sync deassert):
  - count=0, pointers=0, idu_vld=0, ifu_rdy=1.
  - idu_pc=RESET_PC; all other outputs 0.
  - Reset mid-operation drops every entry.
- Push = ifu_vld & ifu_rdy. Pop = idu_vld & exu_rdy.
- ifu_rdy depends only on registered count. When full, no push occurs even if a pop happens the same cycle, so no combinational ready path exists.
- Latency: an instruction pushed at edge N is visible on idu_vld at cycle N+1 when the queue was empty. No bypass.
- Decode is combinational on ifu_inst. The full decode bundle is written into the entry at push.
- Outputs are read from the entry at rd_ptr. When empty, payload outputs are forced to 0 and idu_pc holds its last value.
- Pointers wrap modulo DEPTH.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, including at count=1 with the same entry pushed and popped on consecutive edges.
- flush (priority over push/pop): next count=0, pointers=0, idu_vld=0 next cycle. An instruction offered in the flush cycle is dropped.
- Immediate:
  - I: inst[31:20]
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - U: {inst[31:12], 12'b0}
  - All sign-extended from inst[31] to XLEN. R type and illegal: 0.
- fmt by opcode:
  - I: OP-IMM, JALR, LOAD, OP-IMM-32, SYSTEM
  - U: LUI, AUIPC
  - S: STORE
  - J: JAL
  - R: OP, OP-32
  - B: BRANCH
- illegal:
  - Opcode outside the above set, or inst[1:0] != 2'b11.
  - When XLEN=32: also OP-IMM-32/OP-32, LOAD funct3 011/110, STORE funct3 011.
  - On illegal, all other ctl bits are 0; the entry is still queued so EXU can trap.
- wb: R, J, U, or I excluding ecall/ebreak/mret.
- mul/div: R with inst[25]; split by inst[14].
- w_inst: OP-32 or OP-IMM-32.

Optional Feature:
- Macro IDU_QUEUE_PERF_EN.
- With it defined:
  - Two 32-bit outputs, perf_dec (pops) and perf_stall (cycles with ifu_vld & ~ifu_rdy).
  - Both wrap at 2^32, clear on rst, and are not cleared by flush.
- Without it defined: the ports and counters do not exist.

Test Plan:
- XLEN=64, push 0x00500093 (addi x1,x0,5), exu_rdy=1 -> next cycle idu_vld=1, rd=1, rs1=0, imm=5, fmt=I, wb=1; following cycle idu_vld=0.
- XLEN=64, push 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt=U. Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFFFFFFFFFC, br=1, wb=0.
- DEPTH=4, exu_rdy=0, ifu_vld=1 continuously -> ifu_rdy falls after 4th push, idu_count=4. Raise exu_rdy for one cycle -> count 3, ifu_rdy=1 next cycle. FIFO order of idu_pc preserved across pointer wrap.
- count=3, assert flush with ifu_vld=1 and exu_rdy=1 -> next cycle count=0, idu_vld=0, flushed instruction never appears.
- XLEN=32, push 0x0010009B (addiw) and 0x00000000 -> both emerge with illegal=1, fmt=0, wb=0, imm=0.
- Assert rst asynchronously mid-burst with count=2 -> idu_vld=0 and idu_pc=RESET_PC without a clock edge. After deassert, first push appears after 1 cycle.

Source files
------------

// File: rtl/idu_queue.sv
// idu_queue: RV32I/RV64I(+M) decode stage feeding a DEPTH-entry queue of
// decoded instructions, with valid/ready handshakes toward IFU and EXU.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush            drop every queued entry and this cycle's input
//   ifu_vld/ifu_rdy  IFU handshake (ifu_rdy = count < DEPTH)
//   ifu_inst/ifu_pc  instruction word and its PC
//   idu_vld/exu_rdy  EXU handshake on the queue head
//   idu_pc/idu_inst  head PC and instruction word
//   rd/rs1/rs2       head register indices
//   imm              head sign-extended immediate
//   fmt              head one-hot {B,R,J,S,U,I}, 0 if illegal
//   ctl              {illegal,w_inst,mul,div,sys,jalr,jal,br,st,ld,wb,sign}
//   idu_count        queue occupancy
//
// Optional feature, enabled by defining IDU_QUEUE_PERF_EN:
//   perf_dec         32-bit count of pops
//   perf_stall       32-bit count of cycles with ifu_vld & ~ifu_rdy
// Both clear only on rst.

module idu_queue #(
  parameter int          XLEN     = 64,
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   ifu_vld,
  output logic                   ifu_rdy,
  input  logic [31:0]            ifu_inst,
  input  logic [XLEN-1:0]        ifu_pc,
  output logic                   idu_vld,
  input  logic                   exu_rdy,
  output logic [XLEN-1:0]        idu_pc,
  output logic [31:0]            idu_inst,
  output logic [4:0]             rd,
  output logic [4:0]             rs1,
  output logic [4:0]             rs2,
  output logic [XLEN-1:0]        imm,
  output logic [5:0]             fmt,
  output logic [11:0]            ctl,
  output logic [$clog2(DEPTH):0] idu_count
`ifdef IDU_QUEUE_PERF_EN
  ,
  output logic [31:0]            perf_dec,
  output logic [31:0]            perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [5:0]      fmt;
    logic [11:0]     ctl;
  } ent_t;

  // ---------------- decode ----------------
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_ld, w_opi, w_aui, w_opiw, w_st, w_op;
  logic            w_lui, w_opw, w_br, w_jalr, w_jal, w_sys;
  logic            w_known, w_rv64, w_ill, w_nowb;
  logic            w_wb, w_mul, w_div;
  logic [5:0]      w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic [11:0]     w_ctl;
  ent_t            w_ent;

  assign w_opc = ifu_inst[6:0];
  assign w_f3  = ifu_inst[14:12];

  // Full 7-bit compares also reject inst[1:0] != 2'b11.
  assign w_ld   = (w_opc == 7'h03);
  assign w_opi  = (w_opc == 7'h13);
  assign w_aui  = (w_opc == 7'h17);
  assign w_opiw = (w_opc == 7'h1B);
  assign w_st   = (w_opc == 7'h23);
  assign w_op   = (w_opc == 7'h33);
  assign w_lui  = (w_opc == 7'h37);
  assign w_opw  = (w_opc == 7'h3B);
  assign w_br   = (w_opc == 7'h63);
  assign w_jalr = (w_opc == 7'h67);
  assign w_jal  = (w_opc == 7'h6F);
  assign w_sys  = (w_opc == 7'h73);

  assign w_known = w_ld | w_opi | w_aui | w_opiw | w_st | w_op |
                   w_lui | w_opw | w_br | w_jalr | w_jal | w_sys;

  // Encodings that only exist on RV64 (word ops, LD/LWU, SD).
  assign w_rv64 = w_opiw | w_opw |
                  (w_ld & ((w_f3 == 3'b011) | (w_f3 == 3'b110))) |
                  (w_st & (w_f3 == 3'b011));

  assign w_ill = ~w_known | ((XLEN == 32) & w_rv64);

  assign w_fmt = w_ill ? 6'b0 : {
    w_br,
    w_op | w_opw,
    w_jal,
    w_st,
    w_lui | w_aui,
    w_ld | w_opi | w_opiw | w_jalr | w_sys
  };

  always_comb begin
    w_imm32 = '0;
    unique case (1'b1)
      w_fmt[0]: w_imm32 = {{20{ifu_inst[31]}}, ifu_inst[31:20]};
      w_fmt[1]: w_imm32 = {ifu_inst[31:12], 12'b0};
      w_fmt[2]: w_imm32 = {{20{ifu_inst[31]}}, ifu_inst[31:25],
                           ifu_inst[11:7]};
      w_fmt[3]: w_imm32 = {{11{ifu_inst[31]}}, ifu_inst[31],
                           ifu_inst[19:12], ifu_inst[20],
                           ifu_inst[30:21], 1'b0};
      w_fmt[5]: w_imm32 = {{19{ifu_inst[31]}}, ifu_inst[31],
                           ifu_inst[7], ifu_inst[30:25],
                           ifu_inst[11:8], 1'b0};
      default:  w_imm32 = '0;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  // ecall, ebreak and mret write no register.
  assign w_nowb = w_sys & ((ifu_inst == 32'h0000_0073) |
                           (ifu_inst == 32'h0010_0073) |
                           (ifu_inst == 32'h3020_0073));

  assign w_wb  = w_fmt[4] | w_fmt[3] | w_fmt[1] |
                 (w_fmt[0] & ~w_nowb);
  assign w_mul = w_fmt[4] & ifu_inst[25] & ~ifu_inst[14];
  assign w_div = w_fmt[4] & ifu_inst[25] &  ifu_inst[14];

  // sign: the immediate is negative.
  assign w_ctl = {
    w_ill,
    ~w_ill & (w_opiw | w_opw),
    w_mul,
    w_div,
    ~w_ill & w_sys,
    ~w_ill & w_jalr,
    ~w_ill & w_jal,
    ~w_ill & w_br,
    ~w_ill & w_st,
    ~w_ill & w_ld,
    w_wb,
    w_imm[XLEN-1]
  };

  assign w_ent = '{pc: ifu_pc, inst: ifu_inst, imm: w_imm,
                   fmt: w_fmt, ctl: w_ctl};

  // ---------------- queue ----------------
  ent_t            r_q [DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hold;
  ent_t            w_head;
  logic            w_push, w_pop;

  assign w_head  = r_q[r_rd];
  assign idu_vld = (r_cnt != '0);
  // Ready comes from the registered count only: a full queue never
  // accepts, even when EXU pops in the same cycle.
  assign ifu_rdy = (r_cnt != CW'(DEPTH));
  assign w_push  = ifu_vld & ifu_rdy & ~flush;
  assign w_pop   = idu_vld & exu_rdy & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_hold <= RESET_PC[XLEN-1:0];
    end else begin
      // Remember the head PC so idu_pc holds it once the queue drains.
      if (idu_vld) r_hold <= w_head.pc;
      if (flush) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + 1'b1;
        if (w_pop)  r_rd <= r_rd + 1'b1;
        unique case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + 1'b1;
          2'b01:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= w_ent;
  end

  assign idu_pc    = idu_vld ? w_head.pc   : r_hold;
  assign idu_inst  = idu_vld ? w_head.inst : '0;
  assign imm       = idu_vld ? w_head.imm  : '0;
  assign fmt       = idu_vld ? w_head.fmt  : '0;
  assign ctl       = idu_vld ? w_head.ctl  : '0;
  assign rd        = idu_inst[11:7];
  assign rs1       = idu_inst[19:15];
  assign rs2       = idu_inst[24:20];
  assign idu_count = r_cnt;

`ifdef IDU_QUEUE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dec   <= '0;
      perf_stall <= '0;
    end else begin
      if (w_pop) perf_dec <= perf_dec + 32'd1;
      if (ifu_vld & ~ifu_rdy) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_idu_queue.sv
// tb_idu_queue: randomized scoreboard bench for idu_queue.
// Drives an XLEN=64 and an XLEN=32 instance from the same stimulus.

module tb_idu_queue;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        ifu_vld = 0;
  logic        exu_rdy = 0;
  logic [31:0] ifu_inst = '0;
  logic [63:0] ifu_pc = '0;

  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [63:0] pc_a, imm_a;
  logic [31:0] pc_b, imm_b, inst_a, inst_b;
  logic [4:0]  rd_a, rs1_a, rs2_a, rd_b, rs1_b, rs2_b;
  logic [5:0]  fmt_a, fmt_b;
  logic [11:0] ctl_a, ctl_b;
  logic [2:0]  cnt_a, cnt_b;
`ifdef IDU_QUEUE_PERF_EN
  logic [31:0] pd_a, ps_a, pd_b, ps_b;
`endif

  idu_queue #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(RPC)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .ifu_vld(ifu_vld), .ifu_rdy(rdy_a),
    .ifu_inst(ifu_inst), .ifu_pc(ifu_pc),
    .idu_vld(vld_a), .exu_rdy(exu_rdy),
    .idu_pc(pc_a), .idu_inst(inst_a),
    .rd(rd_a), .rs1(rs1_a), .rs2(rs2_a),
    .imm(imm_a), .fmt(fmt_a), .ctl(ctl_a),
    .idu_count(cnt_a)
`ifdef IDU_QUEUE_PERF_EN
    , .perf_dec(pd_a), .perf_stall(ps_a)
`endif
  );

  idu_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .ifu_vld(ifu_vld), .ifu_rdy(rdy_b),
    .ifu_inst(ifu_inst), .ifu_pc(ifu_pc[31:0]),
    .idu_vld(vld_b), .exu_rdy(exu_rdy),
    .idu_pc(pc_b), .idu_inst(inst_b),
    .rd(rd_b), .rs1(rs1_b), .rs2(rs2_b),
    .imm(imm_b), .fmt(fmt_b), .ctl(ctl_b),
    .idu_count(cnt_b)
`ifdef IDU_QUEUE_PERF_EN
    , .perf_dec(pd_b), .perf_stall(ps_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } txn_t;

  typedef struct {
    logic [63:0] imm;
    logic [5:0]  fmt;
    logic [11:0] ctl;
  } dec_t;

  txn_t        mq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          pend = 0;
  logic [63:0] hold_exp = RPC;
  int          n_pop = 0;
  int          n_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference decoder, written straight from the ISA field tables.
  function automatic dec_t model(input logic [31:0] i, input bit x64);
    dec_t       d;
    byte        f;
    logic [2:0] f3;
    bit ill, w, ld, st, br, jal, jalr, sys, wb, mul, div;
    d = '{imm: '0, fmt: '0, ctl: '0};
    f = 0; f3 = i[14:12];
    ill = 0; w = 0; ld = 0; st = 0; br = 0; jal = 0;
    jalr = 0; sys = 0; wb = 0; mul = 0; div = 0;
    case (i[6:0])
      7'h03: begin f = "I"; ld = 1;
                   ill = !x64 && (f3 == 3'b011 || f3 == 3'b110); end
      7'h13: f = "I";
      7'h1B: begin f = "I"; w = 1; ill = !x64; end
      7'h67: begin f = "I"; jalr = 1; end
      7'h73: begin f = "I"; sys = 1; end
      7'h37, 7'h17: f = "U";
      7'h23: begin f = "S"; st = 1; ill = !x64 && f3 == 3'b011; end
      7'h6F: begin f = "J"; jal = 1; end
      7'h33: f = "R";
      7'h3B: begin f = "R"; w = 1; ill = !x64; end
      7'h63: begin f = "B"; br = 1; end
      default: ill = 1;
    endcase
    if (ill) begin
      d.ctl = 12'h800;
      return d;
    end
    case (f)
      "I": begin d.fmt = 6'b000001;
                 d.imm = {{52{i[31]}}, i[31:20]}; end
      "U": begin d.fmt = 6'b000010;
                 d.imm = {{32{i[31]}}, i[31:12], 12'h000}; end
      "S": begin d.fmt = 6'b000100;
                 d.imm = {{52{i[31]}}, i[31:25], i[11:7]}; end
      "J": begin d.fmt = 6'b001000;
                 d.imm = {{43{i[31]}}, i[31], i[19:12], i[20],
                          i[30:21], 1'b0}; end
      "B": begin d.fmt = 6'b100000;
                 d.imm = {{51{i[31]}}, i[31], i[7], i[30:25],
                          i[11:8], 1'b0}; end
      "R": begin d.fmt = 6'b010000;
                 mul = i[25] && !i[14];
                 div = i[25] && i[14]; end
      default: ;
    endcase
    wb = (f == "R") || (f == "J") || (f == "U") ||
         (f == "I" && !(i == 32'h00000073 || i == 32'h00100073 ||
                        i == 32'h30200073));
    d.ctl = {1'b0, w, mul, div, sys, jalr, jal, br, st, ld, wb,
             d.imm[63]};
    return d;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          s;
    r = $urandom;
    s = $urandom_range(0, 17);
    case (s)
      0:  return {r[31:7], 7'h03};
      1:  return {r[31:7], 7'h13};
      2:  return {r[31:7], 7'h17};
      3:  return {r[31:7], 7'h1B};
      4:  return {r[31:7], 7'h23};
      5:  return {r[31:7], 7'h33};
      6:  return {r[31:7], 7'h37};
      7:  return {r[31:7], 7'h3B};
      8:  return {r[31:7], 7'h63};
      9:  return {r[31:7], 7'h67};
      10: return {r[31:7], 7'h6F};
      11: return {r[31:7], 7'h73};
      12: return 32'h00000073;
      13: return 32'h00100073;
      14: return 32'h30200073;
      15: return {7'b0000001, r[24:7], r[0] ? 7'h33 : 7'h3B};
      16: return {r[31:2], 2'b00};
      default: return r;
    endcase
  endfunction

  // Drive one cycle's inputs just after the edge; record an expected
  // entry when the next edge will accept it.
  task automatic cyc(input bit v, input logic [31:0] ins,
                     input logic [63:0] pc, input bit er, input bit fl);
    @(posedge clk);
    #1;
    ifu_vld  = v;
    ifu_inst = ins;
    ifu_pc   = pc;
    exu_rdy  = er;
    flush    = fl;
    pend     = v && rdy_a && !fl;
    if (pend) mq.push_back('{inst: ins, pc: pc});
    @(negedge clk);
  endtask

  // Monitor: compare the presented head with the scoreboard each cycle.
  always @(negedge clk) begin : mon
    int   ec;
    txn_t e;
    dec_t d64, d32;
    if (!rst) begin
      ec = mq.size() - int'(pend);
      chk("count64", 64'(cnt_a), 64'(ec));
      chk("count32", 64'(cnt_b), 64'(ec));
      chk("vld64", 64'(vld_a), 64'(ec != 0));
      chk("vld32", 64'(vld_b), 64'(ec != 0));
      chk("rdy64", 64'(rdy_a), 64'(ec < DEPTH));
      chk("rdy32", 64'(rdy_b), 64'(ec < DEPTH));
      if (ifu_vld && ec == DEPTH) n_stall++;
      if (ec != 0) begin
        e   = mq[0];
        d64 = model(e.inst, 1'b1);
        d32 = model(e.inst, 1'b0);
        chk("pc64", pc_a, e.pc);
        chk("inst64", 64'(inst_a), 64'(e.inst));
        chk("rd64", 64'(rd_a), 64'(e.inst[11:7]));
        chk("rs1_64", 64'(rs1_a), 64'(e.inst[19:15]));
        chk("rs2_64", 64'(rs2_a), 64'(e.inst[24:20]));
        chk("imm64", imm_a, d64.imm);
        chk("fmt64", 64'(fmt_a), 64'(d64.fmt));
        chk("ctl64", 64'(ctl_a), 64'(d64.ctl));
        chk("pc32", 64'(pc_b), 64'(e.pc[31:0]));
        chk("inst32", 64'(inst_b), 64'(e.inst));
        chk("rd32", 64'(rd_b), 64'(e.inst[11:7]));
        chk("imm32", 64'(imm_b), 64'(d32.imm[31:0]));
        chk("fmt32", 64'(fmt_b), 64'(d32.fmt));
        chk("ctl32", 64'(ctl_b), 64'(d32.ctl));
        hold_exp = e.pc;
      end else begin
        chk("hold64", pc_a, hold_exp);
        chk("hold32", 64'(pc_b), 64'(hold_exp[31:0]));
        chk("zero64", 64'(|{inst_a, imm_a, fmt_a, ctl_a}), 64'(0));
        chk("zero32", 64'(|{inst_b, imm_b, fmt_b, ctl_b}), 64'(0));
      end
      if (flush) begin
        mq.delete();
      end else if (ec != 0 && exu_rdy) begin
        void'(mq.pop_front());
        n_pop++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [63:0] pc;
    bit          er;

    repeat (2) @(negedge clk);
    chk("rst_vld", 64'(vld_a), 64'(0));
    chk("rst_rdy", 64'(rdy_a), 64'(1));
    chk("rst_cnt", 64'(cnt_a), 64'(0));
    chk("rst_pc", pc_a, RPC);
    chk("rst_pc32", 64'(pc_b), 64'(RPC[31:0]));
    chk("rst_ctl", 64'(ctl_a), 64'(0));
    rst = 0;

    // addi x1,x0,5
    cyc(1, 32'h00500093, 64'h100, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("t1_vld", 64'(vld_a), 64'(1));
    chk("t1_rd", 64'(rd_a), 64'(1));
    chk("t1_rs1", 64'(rs1_a), 64'(0));
    chk("t1_imm", imm_a, 64'd5);
    chk("t1_fmt", 64'(fmt_a), 64'(6'b000001));
    chk("t1_wb", 64'(ctl_a[1]), 64'(1));
    cyc(0, 0, 0, 1, 0);
    chk("t1_empty", 64'(vld_a), 64'(0));
    chk("t1_hold", pc_a, 64'h100);

    // lui then beq
    cyc(1, 32'h800000B7, 64'h200, 0, 0);
    cyc(1, 32'hFE000EE3, 64'h204, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_lui_imm", imm_a, 64'hFFFFFFFF80000000);
    chk("t2_lui_fmt", 64'(fmt_a), 64'(6'b000010));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t2_beq_imm", imm_a, 64'hFFFFFFFFFFFFFFFC);
    chk("t2_beq_br", 64'(ctl_a[4]), 64'(1));
    chk("t2_beq_wb", 64'(ctl_a[1]), 64'(0));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // fill to full, single pop, then stream across pointer wrap
    for (int k = 0; k < 6; k++)
      cyc(1, {12'(k), 13'h0, 7'h13}, 64'h300 + 64'(4 * k), 0, 0);
    chk("t3_full_cnt", 64'(cnt_a), 64'(4));
    chk("t3_full_rdy", 64'(rdy_a), 64'(0));
    cyc(1, 32'h00700093, 64'h400, 1, 0);
    cyc(1, 32'h00700093, 64'h400, 0, 0);
    chk("t3_pop_cnt", 64'(cnt_a), 64'(3));
    chk("t3_pop_rdy", 64'(rdy_a), 64'(1));
    for (int k = 0; k < 10; k++)
      cyc(1, {12'(k + 16), 13'h0, 7'h13}, 64'h500 + 64'(4 * k), 1, 0);
    repeat (6) cyc(0, 0, 0, 1, 0);

    // flush at count 3 with a concurrent offer and pop
    for (int k = 0; k < 3; k++)
      cyc(1, 32'h00100093, 64'h600 + 64'(4 * k), 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t4_cnt3", 64'(cnt_a), 64'(3));
    cyc(1, 32'h7FF00F93, 64'h999, 1, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t4_cnt0", 64'(cnt_a), 64'(0));
    chk("t4_vld0", 64'(vld_a), 64'(0));
    cyc(0, 0, 0, 1, 0);

    // RV64-only and all-zero words on the XLEN=32 instance
    cyc(1, 32'h0010009B, 64'h700, 0, 0);
    cyc(1, 32'h00000000, 64'h704, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_addiw_ctl32", 64'(ctl_b), 64'(12'h800));
    chk("t5_addiw_fmt32", 64'(fmt_b), 64'(0));
    chk("t5_addiw_imm32", 64'(imm_b), 64'(0));
    chk("t5_addiw_w64", 64'(ctl_a[10]), 64'(1));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_zero_ctl32", 64'(ctl_b), 64'(12'h800));
    chk("t5_zero_ill64", 64'(ctl_a[11]), 64'(1));
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // asynchronous reset with two entries queued
    cyc(1, 32'h00200093, 64'h800, 0, 0);
    cyc(1, 32'h00300093, 64'h804, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_cnt2", 64'(cnt_a), 64'(2));
    #2;
    rst = 1;
    ifu_vld = 0;
    #1;
    chk("t6_async_vld", 64'(vld_a), 64'(0));
    chk("t6_async_pc", pc_a, RPC);
    chk("t6_async_pc32", 64'(pc_b), 64'(RPC[31:0]));
    chk("t6_async_cnt", 64'(cnt_a), 64'(0));
    mq.delete();
    pend = 0;
    hold_exp = RPC;
    n_pop = 0;
    n_stall = 0;
    @(negedge clk);
    rst = 0;
    cyc(1, 32'h00500093, 64'h900, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("t6_first_vld", 64'(vld_a), 64'(1));
    chk("t6_first_pc", pc_a, 64'h900);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // randomized traffic, alternating drain-heavy and fill-heavy phases
    for (int c = 0; c < 1500; c++) begin
      ins = rand_inst();
      pc  = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
      er  = ((c / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 3) != 0, ins, pc, er,
          $urandom_range(0, 39) == 0);
    end
    repeat (8) cyc(0, 0, 0, 1, 0);

`ifdef IDU_QUEUE_PERF_EN
    chk("perf_dec64", 64'(pd_a), 64'(n_pop));
    chk("perf_stall64", 64'(ps_a), 64'(n_stall));
    chk("perf_dec32", 64'(pd_b), 64'(n_pop));
    chk("perf_stall32", 64'(ps_b), 64'(n_stall));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
